dbg_reg_reporter: RTL and testbench

- Periodically prints NUM_REGS status registers (PHY ID, BMSR, link flags, etc.) over the debug UART as ASCII lines of the form `<label><hex value>CR LF`.
- Sits between status sources and the existing uart transmitter; drives its txd/txv and obeys its cts.
- Generalises the single-register PHY ID printer to N labelled registers of any width, with a trigger input and a change-only reporting option.

---
 rtl/dbg_report_pkg.sv | 29 ++
 rtl/dbg_poll_timer.sv | 32 +++
 rtl/dbg_reg_reporter.sv | 199 +++++++++++++++++++
 tb/tb_dbg_reg_reporter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbg_report_pkg.sv
`default_nettype none
// ============================================================================
// dbg_report_pkg : shared state encoding and ASCII helpers for debug reporters
// Rev 1.0
// ============================================================================
package dbg_report_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LABEL = 3'd1,
        ST_HEX   = 3'd2,
        ST_CR    = 3'd3,
        ST_LF    = 3'd4
    } state_t;

    localparam logic [7:0] ASCII_CR = 8'h0d;
    localparam logic [7:0] ASCII_LF = 8'h0a;

    // Lowercase hex: 'a' (0x61) minus 10 gives the 0x57 offset.
    function automatic logic [7:0] hex2ascii(input logic [3:0] nib);
        hex2ascii = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h57 + {4'h0, nib});
    endfunction

    function automatic int hex_digit_count(input int width);
        hex_digit_count = (width + 3) / 4;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dbg_poll_timer.sv
`default_nettype none
// ============================================================================
// dbg_poll_timer : free-running 0..POLL_TICKS-1 counter, one-cycle tick at TC
// Rev 1.0
// ============================================================================
module dbg_poll_timer #(
    parameter int POLL_TICKS = 25000000
) (
    input  logic clk,
    input  logic rst,
    output logic tick_o
);

    localparam int              CNT_W  = (POLL_TICKS > 1) ? $clog2(POLL_TICKS) : 1;
    localparam logic [CNT_W-1:0] C_TERM = CNT_W'(POLL_TICKS - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (cnt_q == C_TERM) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign tick_o = (cnt_q == C_TERM);

endmodule
`default_nettype wire

// File: rtl/dbg_reg_reporter.sv
`default_nettype none
// ============================================================================
// dbg_reg_reporter : prints NUM_REGS labelled hex registers as ASCII lines
// Option macro: DBG_REPORT_ON_CHANGE_EN (skip registers unchanged since last print)
// Rev 1.0
// ============================================================================
module dbg_reg_reporter
    import dbg_report_pkg::*;
#(
    parameter int NUM_REGS   = 4,
    parameter int REG_W      = 16,
    parameter int LABEL_LEN  = 8,
    parameter logic [NUM_REGS-1:0][LABEL_LEN-1:0][7:0] LABELS = {(NUM_REGS*LABEL_LEN){8'h20}},
    parameter int POLL_TICKS = 25000000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REGS*REG_W-1:0] regs,
    input  logic                      trigger,
    input  logic                      tx_ready,
    output logic [7:0]                tx_data,
    output logic                      tx_valid,
    output logic                      busy
);

    localparam int HEX_DIGITS = hex_digit_count(REG_W);
    localparam int PAD_W      = HEX_DIGITS * 4;
    localparam int CI_MAX     = (LABEL_LEN > HEX_DIGITS) ? LABEL_LEN : HEX_DIGITS;
    localparam int CI_W       = (CI_MAX > 1) ? $clog2(CI_MAX) : 1;
    localparam int RI_W       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    localparam logic [CI_W-1:0] C_LBL_LAST = CI_W'(LABEL_LEN - 1);
    localparam logic [CI_W-1:0] C_HEX_LAST = CI_W'(HEX_DIGITS - 1);
    localparam logic [RI_W-1:0] C_REG_LAST = RI_W'(NUM_REGS - 1);

    state_t            state_q;
    logic [RI_W-1:0]   reg_idx_q;
    logic [CI_W-1:0]   char_idx_q;
    logic [REG_W-1:0]  shadow_q [NUM_REGS];
    logic              pending_q;
    logic              busy_q;
    logic              tx_valid_q;
    logic [7:0]        tx_data_q;

    logic              w_tick;
    logic              w_start_req;
    logic              w_can_send;
    logic              w_skip;
    logic [CI_W-1:0]   w_lbl_sel;
    logic [CI_W-1:0]   w_nib_sel;
    logic [PAD_W-1:0]  w_cur_pad;
    logic [3:0]        w_nib;
    logic [7:0]        w_lbl_byte;

    dbg_poll_timer #(
        .POLL_TICKS (POLL_TICKS)
    ) u_poll_timer (
        .clk    (clk),
        .rst    (rst),
        .tick_o (w_tick)
    );

    assign w_start_req = w_tick | trigger;
    // Gating on our own strobe guarantees at least one idle cycle between bytes.
    assign w_can_send  = tx_ready & ~tx_valid_q;

    assign w_lbl_sel  = C_LBL_LAST - char_idx_q;
    assign w_nib_sel  = C_HEX_LAST - char_idx_q;
    assign w_lbl_byte = LABELS[reg_idx_q][w_lbl_sel];
    assign w_cur_pad  = PAD_W'(shadow_q[reg_idx_q]);
    assign w_nib      = w_cur_pad[{w_nib_sel, 2'b00} +: 4];

`ifdef DBG_REPORT_ON_CHANGE_EN
    logic [REG_W-1:0]    last_q [NUM_REGS];
    logic [NUM_REGS-1:0] seen_q;
    logic                full_q;
    logic                full_pend_q;

    assign w_skip = (char_idx_q == '0) && !full_q && seen_q[reg_idx_q] &&
                    (shadow_q[reg_idx_q] == last_q[reg_idx_q]);
`else
    assign w_skip = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            reg_idx_q  <= '0;
            char_idx_q <= '0;
            pending_q  <= 1'b0;
            busy_q     <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
`ifdef DBG_REPORT_ON_CHANGE_EN
            seen_q      <= '0;
            full_q      <= 1'b0;
            full_pend_q <= 1'b0;
`endif
        end else begin
            tx_valid_q <= 1'b0;
            if (state_q != ST_IDLE && w_start_req) begin
                pending_q <= 1'b1;
            end
`ifdef DBG_REPORT_ON_CHANGE_EN
            if (state_q != ST_IDLE && trigger) begin
                full_pend_q <= 1'b1;
            end
`endif
            case (state_q)
                ST_IDLE: begin
                    if (w_start_req || pending_q) begin
                        for (int i = 0; i < NUM_REGS; i++) begin
                            shadow_q[i] <= regs[i*REG_W +: REG_W];
                        end
                        pending_q  <= 1'b0;
                        busy_q     <= 1'b1;
                        reg_idx_q  <= '0;
                        char_idx_q <= '0;
                        state_q    <= ST_LABEL;
`ifdef DBG_REPORT_ON_CHANGE_EN
                        full_q      <= trigger | full_pend_q;
                        full_pend_q <= 1'b0;
`endif
                    end
                end

                ST_LABEL: begin
                    if (w_skip) begin
                        if (reg_idx_q == C_REG_LAST) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            reg_idx_q <= reg_idx_q + RI_W'(1);
                        end
                    end else if (w_can_send) begin
                        tx_data_q  <= w_lbl_byte;
                        tx_valid_q <= 1'b1;
                        if (char_idx_q == C_LBL_LAST) begin
                            char_idx_q <= '0;
                            state_q    <= ST_HEX;
                        end else begin
                            char_idx_q <= char_idx_q + CI_W'(1);
                        end
                    end
                end

                ST_HEX: begin
                    if (w_can_send) begin
                        tx_data_q  <= hex2ascii(w_nib);
                        tx_valid_q <= 1'b1;
                        if (char_idx_q == C_HEX_LAST) begin
                            char_idx_q <= '0;
                            state_q    <= ST_CR;
                        end else begin
                            char_idx_q <= char_idx_q + CI_W'(1);
                        end
                    end
                end

                ST_CR: begin
                    if (w_can_send) begin
                        tx_data_q  <= ASCII_CR;
                        tx_valid_q <= 1'b1;
                        state_q    <= ST_LF;
                    end
                end

                ST_LF: begin
                    if (w_can_send) begin
                        tx_data_q  <= ASCII_LF;
                        tx_valid_q <= 1'b1;
`ifdef DBG_REPORT_ON_CHANGE_EN
                        last_q[reg_idx_q] <= shadow_q[reg_idx_q];
                        seen_q[reg_idx_q] <= 1'b1;
`endif
                        if (reg_idx_q == C_REG_LAST) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            reg_idx_q <= reg_idx_q + RI_W'(1);
                            state_q   <= ST_LABEL;
                        end
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign busy     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_dbg_reg_reporter.sv
`default_nettype none
// ============================================================================
// tb_dbg_reg_reporter : line-level reference model plus directed report scenarios
// Rev 1.0
// ============================================================================
module tb_dbg_reg_reporter;

    localparam int NREG = 2;
    localparam int POLL = 100;
`ifdef DBG_REPORT_ON_CHANGE_EN
    localparam bit CHG_MODE = 1'b1;
`else
    localparam bit CHG_MODE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] regs;
    logic        trigger;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        busy;

    logic [9:0]  regs2;
    logic        tx_ready2;
    logic [7:0]  tx_data2;
    logic        tx_valid2;
    logic        busy2;

    always #5 clk = ~clk;

    dbg_reg_reporter #(
        .NUM_REGS   (2),
        .REG_W      (16),
        .LABEL_LEN  (4),
        .LABELS     ({"ID2:", "ID1:"}),
        .POLL_TICKS (POLL)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .regs     (regs),
        .trigger  (trigger),
        .tx_ready (tx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .busy     (busy)
    );

    dbg_reg_reporter #(
        .NUM_REGS   (1),
        .REG_W      (10),
        .LABEL_LEN  (2),
        .LABELS     ("R:"),
        .POLL_TICKS (20)
    ) dut2 (
        .clk      (clk),
        .rst      (rst),
        .regs     (regs2),
        .trigger  (1'b0),
        .tx_ready (tx_ready2),
        .tx_data  (tx_data2),
        .tx_valid (tx_valid2),
        .busy     (busy2)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;
    bit rnd_en = 1'b0;

    logic [7:0] dut_bytes[$];
    logic [7:0] q2[$];

    string S_OLD = "ID1:0022\015\012ID2:1622\015\012";
    string S_NEW = "ID1:beef\015\012ID2:beef\015\012";
    string lbl_m [NREG] = '{"ID1:", "ID2:"};

    // Reference model state: a report is a queue of bytes (bit 8 marks a skipped register).
    logic [8:0]  mq[$];
    int          poll_m      = 0;
    bit          in_rep      = 1'b0;
    bit          pend_m      = 1'b0;
    bit          full_pend_m = 1'b0;
    logic        exp_valid   = 1'b0;
    logic        exp_busy    = 1'b0;
    logic [7:0]  exp_data    = 8'h00;
    logic [15:0] last_m [NREG];
    bit          vld_m  [NREG];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic chk_str(input string nm, input logic [7:0] q[$], input int base, input string s);
        for (int i = 0; i < s.len(); i++) begin
            if (base + i < q.size()) chk(nm, {24'h0, q[base+i]}, {24'h0, s[i]});
            else chk(nm, 32'hdead_0000, {24'h0, s[i]});
        end
    endtask

    task automatic model_build(input bit full);
        string       line;
        logic [15:0] v;
        for (int r = 0; r < NREG; r++) begin
            v = regs[r*16 +: 16];
            if (CHG_MODE && !full && vld_m[r] && last_m[r] == v) begin
                mq.push_back(9'h100);
            end else begin
                line = {lbl_m[r], $sformatf("%04h", v), "\015\012"};
                for (int k = 0; k < line.len(); k++) mq.push_back({1'b0, line[k]});
            end
            last_m[r] = v;
            vld_m[r]  = 1'b1;
        end
    endtask

    always @(posedge clk) cyc++;

    always @(posedge clk) begin : model
        bit         req;
        bit         prev_v;
        logic [8:0] ent;
        if (rst) begin
            poll_m = 0; in_rep = 0; pend_m = 0; full_pend_m = 0;
            mq.delete();
            exp_valid = 0; exp_busy = 0; exp_data = 8'h00;
            for (int r = 0; r < NREG; r++) vld_m[r] = 1'b0;
        end else begin
            prev_v    = exp_valid;
            exp_valid = 1'b0;
            req       = (poll_m == POLL - 1) || trigger;
            poll_m    = (poll_m == POLL - 1) ? 0 : poll_m + 1;
            if (!in_rep) begin
                if (req || pend_m) begin
                    model_build(trigger || full_pend_m);
                    pend_m = 0; full_pend_m = 0; in_rep = 1;
                end
            end else begin
                if (req) pend_m = 1;
                if (trigger) full_pend_m = 1;
                ent = mq[0];
                if (ent[8]) begin
                    void'(mq.pop_front());
                end else if (tx_ready && !prev_v) begin
                    ent       = mq.pop_front();
                    exp_data  = ent[7:0];
                    exp_valid = 1'b1;
                end
                if (mq.size() == 0) in_rep = 0;
            end
            exp_busy = in_rep;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("tx_valid", {31'h0, tx_valid}, {31'h0, exp_valid});
            chk("busy", {31'h0, busy}, {31'h0, exp_busy});
            chk("tx_data", {24'h0, tx_data}, {24'h0, exp_data});
            if (tx_valid === 1'b1) dut_bytes.push_back(tx_data);
        end
        if (tx_valid2 === 1'b1) q2.push_back(tx_data2);
    end

    initial begin
        tx_ready = 1'b1;
        forever begin
            @(negedge clk);
            tx_ready = rnd_en ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    task automatic wait_bytes(input int n, input int budget);
        int k = 0;
        while (dut_bytes.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (dut_bytes.size() < n) chk("wait_bytes_timeout", dut_bytes.size(), n);
    endtask

    task automatic start_delay(input string nm, input int expd);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (busy !== 1'b1 && k < 300);
        chk(nm, k, expd);
    endtask

`ifdef DBG_REPORT_ON_CHANGE_EN
    task automatic run_change();
        int k;
        start_delay("chg_start_latency", 100);
        wait_bytes(20, 200);
        chk_str("chg_first_report", dut_bytes, 0, S_OLD);
        repeat (130) @(negedge clk);
        chk("chg_silent_report", dut_bytes.size(), 20);
        regs[31:16] = 16'h1623;
        wait_bytes(30, 200);
        chk_str("chg_only_reg1", dut_bytes, 20, "ID2:1623\015\012");
        k = 0;
        while (busy !== 1'b0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
        wait_bytes(50, 200);
        chk_str("chg_trigger_full", dut_bytes, 30, "ID1:0022\015\012ID2:1623\015\012");
    endtask
`else
    task automatic run_default();
        int base;
        start_delay("first_start_latency", 100);
        wait_bytes(20, 200);
        chk_str("report1", dut_bytes, 0, S_OLD);
        chk("dut2_bytes_seen", {31'h0, q2.size() >= 14}, 32'h1);
        chk_str("dut2_10bit_a", q2, 0, "R:3ff\015\012");
        chk_str("dut2_10bit_b", q2, 7, "R:3ff\015\012");

        rnd_en = 1'b1;
        wait_bytes(40, 300);
        rnd_en = 1'b0;
        chk_str("report2_random_ready", dut_bytes, 20, S_OLD);

        wait_bytes(45, 300);
        @(negedge clk);
        trigger = 1'b1;
        regs    = {16'hbeef, 16'hbeef};
        @(negedge clk);
        trigger = 1'b0;
        repeat (5) @(negedge clk);
        trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
        wait_bytes(80, 300);
        chk_str("report3_old_snapshot", dut_bytes, 40, S_OLD);
        chk_str("report4_new_values", dut_bytes, 60, S_NEW);
        repeat (10) @(negedge clk);
        chk("no_extra_report", dut_bytes.size(), 80);

        wait_bytes(85, 200);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_hex_valid", {31'h0, tx_valid}, 32'h0);
        chk("rst_mid_hex_busy", {31'h0, busy}, 32'h0);
        base = dut_bytes.size();
        rst  = 1'b0;
        start_delay("restart_latency", 100);
        wait_bytes(base + 20, 200);
        chk_str("after_reset_report", dut_bytes, base, S_NEW);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d expected under 20000", cyc);
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        trigger   = 1'b0;
        regs      = {16'h1622, 16'h0022};
        regs2     = 10'h3ff;
        tx_ready2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        chk("reset_tx_valid", {31'h0, tx_valid}, 32'h0);
        chk("reset_busy", {31'h0, busy}, 32'h0);
        chk("reset_tx_data", {24'h0, tx_data}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
`ifdef DBG_REPORT_ON_CHANGE_EN
        run_change();
`else
        run_default();
`endif
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
